// File: rtl/color_match_judge_if.sv
// ----------------------------------------------------------------------------
// color_match_judge_if : colour-set / landing bus between game side and judge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface color_match_judge_if #(
  parameter int SCORE_W = 8
);
  logic [11:0]        plats;
  logic [2:0]         ball_color;
  logic               land_valid;
  logic [1:0]         land_section;
  logic               start;
  logic               new_round;
  logic               ready;
  logic [2:0]         cur_ball;
  logic [11:0]        cur_plats;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [3:0]         streak;
  logic [2:0]         lives;
  logic               game_over;

  modport master (
    output plats, ball_color, land_valid, land_section, start,
    input  new_round, ready, cur_ball, cur_plats, hit, miss,
           score, streak, lives, game_over
  );

  modport slave (
    input  plats, ball_color, land_valid, land_section, start,
    output new_round, ready, cur_ball, cur_plats, hit, miss,
           score, streak, lives, game_over
  );
endinterface

`default_nettype wire

// File: rtl/color_match_judge.sv
// ----------------------------------------------------------------------------
// color_match_judge : snapshots a colour set and judges each ball landing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module color_match_judge #(
  parameter int SCORE_W       = 8,
  parameter int LIVES_INIT    = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  color_match_judge_if.slave io_bus
);

  localparam logic [2:0] c_LOAD   = 3'd0;
  localparam logic [2:0] c_SETTLE = 3'd1;
  localparam logic [2:0] c_PLAY   = 3'd2;
  localparam logic [2:0] c_CHECK  = 3'd3;
  localparam logic [2:0] c_OVER   = 3'd4;

  localparam int                 c_CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]         c_LIVES_INIT  = 3'(LIVES_INIT);
  localparam logic [3:0]         c_STREAK_MAX  = 4'hF;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_cur_ball;
  logic [11:0]        r_cur_plats;
  logic [1:0]         r_sec;
  logic               r_hit;
  logic               r_miss;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_streak;
  logic [2:0]         r_lives;

  logic               w_settle_done;
  logic [2:0]         w_sel;
  logic               w_match;
  logic               w_new_round;
  logic               w_ready;
  logic               w_game_over;

  assign w_settle_done = (r_cnt == c_SETTLE_LAST);
  assign w_sel         = r_cur_plats[3*r_sec +: 3];
  // Colour 0 means "unset" and is never a match, even against a 0 section.
  assign w_match       = (w_sel == r_cur_ball) && (r_cur_ball != 3'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_LOAD:   w_state_nxt = c_SETTLE;
      c_SETTLE: if (w_settle_done) w_state_nxt = c_PLAY;
      c_PLAY:   if (io_bus.land_valid) w_state_nxt = c_CHECK;
      c_CHECK: begin
        if (!w_match && (r_lives <= 3'd1)) begin
          w_state_nxt = c_OVER;
        end else begin
          w_state_nxt = c_LOAD;
        end
      end
      c_OVER:   if (io_bus.start) w_state_nxt = c_LOAD;
      default:  w_state_nxt = c_LOAD;
    endcase
  end

  // new_round is masked while reset is held so the LOAD pulse appears only after release.
  always_comb begin
    w_new_round = (r_state == c_LOAD) && resetn;
    w_ready     = (r_state == c_PLAY);
    w_game_over = (r_state == c_OVER);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_cur_ball  <= 3'd0;
      r_cur_plats <= 12'd0;
      r_sec       <= 2'd0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_score     <= '0;
      r_streak    <= 4'd0;
      r_lives     <= c_LIVES_INIT;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        c_LOAD: r_cnt <= '0;
        c_SETTLE: begin
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (w_settle_done) begin
            r_cur_ball  <= io_bus.ball_color;
            r_cur_plats <= io_bus.plats;
          end
        end
        c_PLAY: begin
          if (io_bus.land_valid) r_sec <= io_bus.land_section;
        end
        c_CHECK: begin
          if (w_match) begin
            r_hit <= 1'b1;
            if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + SCORE_W'(1);
            if (r_streak != c_STREAK_MAX) r_streak <= r_streak + 4'd1;
          end else begin
            r_miss   <= 1'b1;
            r_streak <= 4'd0;
            if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
          end
        end
        c_OVER: begin
          if (io_bus.start) begin
            r_score  <= '0;
            r_streak <= 4'd0;
            r_lives  <= c_LIVES_INIT;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign io_bus.new_round = w_new_round;
  assign io_bus.ready     = w_ready;
  assign io_bus.game_over = w_game_over;
  assign io_bus.cur_ball  = r_cur_ball;
  assign io_bus.cur_plats = r_cur_plats;
  assign io_bus.hit       = r_hit;
  assign io_bus.miss      = r_miss;
  assign io_bus.score     = r_score;
  assign io_bus.streak    = r_streak;
  assign io_bus.lives     = r_lives;

endmodule

`default_nettype wire
